// File: rtl/mcdf_fmt_sink.sv
// MCDF formatter sink: grants formatter packets against reserved FIFO space and drains them FWFT with chid/last tags.
// Grant 1 cycle after an accepted request; drain head visible the cycle after write; out_ready low holds the FIFO, grants wait for space.
// Optional per-channel packet counters when MCDF_FMT_SINK_STATS_EN is defined.
module mcdf_fmt_sink #(
  parameter int DEPTH         = 64,
  parameter int START_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fmt_req,
  input  logic [1:0]               fmt_chid,
  input  logic [5:0]               fmt_length,
  output logic                     fmt_grant,
  input  logic                     fmt_start,
  input  logic                     fmt_end,
  input  logic [31:0]              fmt_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [1:0]               out_chid,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   free_words,
  output logic                     err_frame,
  output logic                     err_timeout,
  input  logic                     err_clr
`ifdef MCDF_FMT_SINK_STATS_EN
  ,
  output logic [15:0]              pkt_cnt0,
  output logic [15:0]              pkt_cnt1,
  output logic [15:0]              pkt_cnt2
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;

  state_t          state_q, state_d;
  logic [1:0]      chid_q;
  logic [5:0]      len_q;
  logic [5:0]      beat_q, beat_d;
  logic [3:0]      tmo_q, tmo_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   resv_q, resv_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [34:0]     mem [DEPTH];
  logic [34:0]     head;

  logic wr_en, wr_last, pop, latch, set_frame, set_tmo;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    latch     = 1'b0;
    set_frame = 1'b0;
    set_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fmt_req) begin
          if (fmt_length == 6'd0) begin
            set_frame = 1'b1;
          end else if (free_words >= CW'(fmt_length)) begin
            latch   = 1'b1;
            state_d = GRANT;
          end
        end
      end
      GRANT: begin
        tmo_d   = 4'd0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (fmt_start) begin
          wr_en   = 1'b1;
          wr_last = (len_q == 6'd1);
          beat_d  = 6'd1;
          if (fmt_end != wr_last) set_frame = 1'b1;
          state_d = wr_last ? IDLE : RECV;
        end else if (tmo_q == 4'(START_TIMEOUT - 1)) begin
          set_tmo = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      RECV: begin
        // Beat count alone decides the packet end; fmt_start/fmt_end only flag errors.
        wr_en   = 1'b1;
        beat_d  = beat_q + 6'd1;
        wr_last = (beat_d == len_q);
        if (fmt_start || (fmt_end != wr_last)) set_frame = 1'b1;
        if (wr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop     = (count_q != '0) && out_ready;
  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  always_comb begin
    resv_d = resv_q;
    if (latch)        resv_d = CW'(fmt_length);
    else if (set_tmo) resv_d = '0;
    else if (wr_en)   resv_d = resv_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      chid_q      <= 2'd0;
      len_q       <= 6'd0;
      beat_q      <= 6'd0;
      tmo_q       <= 4'd0;
      count_q     <= '0;
      resv_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      free_words  <= CW'(DEPTH);
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      resv_q     <= resv_d;
      free_words <= CW'(DEPTH) - count_d - resv_d;
      if (latch) begin
        chid_q <= fmt_chid;
        len_q  <= fmt_length;
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      // A new error event outranks a simultaneous clear.
      if (set_frame)    err_frame <= 1'b1;
      else if (err_clr) err_frame <= 1'b0;
      if (set_tmo)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {fmt_data, chid_q, wr_last};
  end

  assign head      = mem[rd_ptr];
  assign fmt_grant = (state_q == GRANT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head[34:3] : 32'd0;
  assign out_chid  = out_valid ? head[2:1]  : 2'd0;
  assign out_last  = out_valid ? head[0]    : 1'b0;

`ifdef MCDF_FMT_SINK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= 16'd0;
      pkt_cnt1 <= 16'd0;
      pkt_cnt2 <= 16'd0;
    end else if (wr_en && wr_last) begin
      case (chid_q)
        2'd0:    pkt_cnt0 <= pkt_cnt0 + 16'd1;
        2'd1:    pkt_cnt1 <= pkt_cnt1 + 16'd1;
        2'd2:    pkt_cnt2 <= pkt_cnt2 + 16'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mcdf_fmt_sink.sv
// Scoreboard bench for mcdf_fmt_sink: directed packets push expected words, a negedge monitor checks every drained word.
module tb_mcdf_fmt_sink;

  logic        clk, rst;
  logic        fmt_req, fmt_start, fmt_end, out_ready, err_clr;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic [31:0] fmt_data;
  logic        fmt_grant, out_valid, out_last, err_frame, err_timeout;
  logic [31:0] out_data;
  logic [1:0]  out_chid;
  logic [6:0]  free_words;
`ifdef MCDF_FMT_SINK_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1, pkt_cnt2;
`endif

  mcdf_fmt_sink #(.DEPTH(64), .START_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .fmt_req(fmt_req), .fmt_chid(fmt_chid), .fmt_length(fmt_length), .fmt_grant(fmt_grant),
    .fmt_start(fmt_start), .fmt_end(fmt_end), .fmt_data(fmt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chid(out_chid), .out_last(out_last), .free_words(free_words),
    .err_frame(err_frame), .err_timeout(err_timeout), .err_clr(err_clr)
`ifdef MCDF_FMT_SINK_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [34:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted drain word must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h expected none", {out_data, out_chid, out_last});
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        chk("drain_word", {29'd0, out_data, out_chid, out_last}, {29'd0, e});
      end
    end
  end

  task automatic do_req(input logic [1:0] chid, input logic [5:0] len);
    @(posedge clk); #1;
    fmt_req    = 1'b1;
    fmt_chid   = chid;
    fmt_length = len;
  endtask

  task automatic wait_grant(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (fmt_grant) begin
        lat = i;
        break;
      end
    end
    fmt_req = 1'b0;
  endtask

  task automatic send_beats(input logic [1:0] chid, input int len, input logic [31:0] base, input int end_beat);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      fmt_start = (i == 0);
      fmt_end   = (i + 1 == end_beat);
      fmt_data  = base + 32'(i);
      sb.push_back({base + 32'(i), chid, (i == len - 1)});
      if (i == 0) begin
        @(negedge clk);
        chk("grant_pulse_width", {63'd0, fmt_grant}, 64'd0);
      end
    end
    @(posedge clk); #1;
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    fmt_data  = 32'd0;
  endtask

  task automatic send_pkt(input logic [1:0] chid, input int len, input logic [31:0] base, input int end_beat);
    int lat;
    do_req(chid, 6'(len));
    wait_grant(10, lat);
    chk("grant_latency", 64'(lat), 64'd2);
    send_beats(chid, len, base, end_beat);
  endtask

  task automatic drain(input int budget);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_valid) break;
    end
    out_ready = 1'b0;
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_errs();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_grant"}, {63'd0, fmt_grant}, 64'd0);
    chk({tag, "_free"}, 64'(free_words), 64'd64);
    chk({tag, "_errs"}, {62'd0, err_frame, err_timeout}, 64'd0);
    chk({tag, "_outs"}, {29'd0, out_data, out_chid, out_last}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int g;
    rst = 1'b1;
    fmt_req = 1'b0; fmt_chid = 2'd0; fmt_length = 6'd0;
    fmt_start = 1'b0; fmt_end = 1'b0; fmt_data = 32'd0;
    out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single packet, chid 1, 8 beats
    send_pkt(2'd1, 8, 32'h100, 8);
    drain(40);
    chk("single_errs", {62'd0, err_frame, err_timeout}, 64'd0);

    // Space reservation: 7 x 8 words stored, 16-word request must wait
    for (int i = 0; i < 7; i++) send_pkt(2'(i % 4), 8, 32'h200 + 32'(i * 16), 8);
    @(negedge clk);
    chk("bp_free_after7", 64'(free_words), 64'd8);
    do_req(2'd0, 6'd16);
    g = 0;
    repeat (10) begin
      @(negedge clk);
      if (fmt_grant) g++;
    end
    chk("bp_no_grant", 64'(g), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b0;
    wait_grant(10, lat);
    chk("bp_grant_after_pop", {63'd0, lat > 0}, 64'd1);
    chk("bp_free_reserved", 64'(free_words), 64'd0);
    send_beats(2'd0, 16, 32'h280, 16);
    drain(100);

    // Framing: fmt_end on beat 3 of a 4-beat packet
    send_pkt(2'd3, 4, 32'h300, 3);
    @(negedge clk);
    chk("frame_err_set", {63'd0, err_frame}, 64'd1);
    chk("frame_free", 64'(free_words), 64'd60);
    drain(20);
    clear_errs();
    chk("frame_err_clr", {63'd0, err_frame}, 64'd0);

    // Start timeout
    do_req(2'd0, 6'd8);
    wait_grant(10, lat);
    chk("tmo_grant_latency", 64'(lat), 64'd2);
    chk("tmo_free_reserved", 64'(free_words), 64'd56);
    repeat (20) @(negedge clk);
    chk("tmo_err_set", {63'd0, err_timeout}, 64'd1);
    chk("tmo_free_released", 64'(free_words), 64'd64);
    chk("tmo_no_words", {63'd0, out_valid}, 64'd0);
    clear_errs();
    chk("tmo_err_clr", {63'd0, err_timeout}, 64'd0);

    // Zero length request
    do_req(2'd1, 6'd0);
    g = 0;
    repeat (6) begin
      @(negedge clk);
      if (fmt_grant) g++;
    end
    fmt_req = 1'b0;
    chk("zero_no_grant", 64'(g), 64'd0);
    chk("zero_err_frame", {63'd0, err_frame}, 64'd1);
    clear_errs();
    chk("zero_err_clr", {63'd0, err_frame}, 64'd0);

    // Reset after beat 2 of 8
    do_req(2'd2, 6'd8);
    wait_grant(10, lat);
    @(posedge clk); #1 fmt_start = 1'b1; fmt_data = 32'h500;
    @(posedge clk); #1 fmt_start = 1'b0; fmt_data = 32'h501;
    @(negedge clk);
    chk("mid_free", 64'(free_words), 64'd56);
    @(posedge clk); #1 rst = 1'b1; fmt_data = 32'd0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(posedge clk); #1 rst = 1'b0;
    send_pkt(2'd2, 4, 32'h400, 4);
    drain(20);
    chk("post_rst_errs", {62'd0, err_frame, err_timeout}, 64'd0);
`ifdef MCDF_FMT_SINK_STATS_EN
    chk("stats_cnt", {16'd0, pkt_cnt0, pkt_cnt1, pkt_cnt2}, {16'd0, 16'd0, 16'd0, 16'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcdf_fmt_sink.md
Name: mcdf_fmt_sink

Overview:
- Receiving end of the MCDF formatter output interface.
- Arbitrates formatter packet requests against its own buffer space and issues `fmt_grant`.
- Captures the framed packet (`fmt_start`/`fmt_end`, `fmt_length` beats) into an internal FIFO, checks framing, and re-presents words on a valid/ready drain port with channel ID and last-beat tag.
- Used as the DUT-side sink in MCDF integration and as a reusable packet collector.

Parameters:
- DEPTH, 64, FIFO depth in 32-bit words; power of two, at least 32.
- START_TIMEOUT, 15, max cycles from grant to `fmt_start` before abort; 4-bit counter range.

Ports:
- clk  input  1  clock
- rst  input  1  reset: one clock; reset is asynchronous and active-high
- fmt_req  input  1  formatter packet request
- fmt_chid  input  2  channel ID of the requested packet
- fmt_length  input  6  packet length in beats; valid with `fmt_req`
- fmt_grant  output  1  one-cycle grant pulse
- fmt_start  input  1  first data beat marker
- fmt_end  input  1  last data beat marker
- fmt_data  input  32  packet data
- out_valid  output  1  drain word valid
- out_ready  input  1  drain consumer ready
- out_data  output  32  drain word
- out_chid  output  2  channel ID of the drain word
- out_last  output  1  last word of packet
- free_words  output  $clog2(DEPTH)+1  current free FIFO entries
- err_frame  output  1  sticky framing error
- err_timeout  output  1  sticky start-timeout error
- err_clr  input  1  clears sticky errors

Behaviour:
- Reset values: `fmt_grant`=0, `out_valid`=0, `out_data`=0, `out_chid`=0, `out_last`=0, `free_words`=DEPTH, `err_frame`=0, `err_timeout`=0, FSM=IDLE, FIFO empty.
- Reset mid-packet: discards the partial packet and all buffered words.
- FSM states: IDLE, GRANT, WAIT_START, RECV.
- IDLE -> GRANT: when `fmt_req`=1, `fmt_length`!=0 and `free_words` >= `fmt_length`. `fmt_chid` and `fmt_length` latch on this edge.
- `fmt_length`=0 with `fmt_req`: never granted; sets `err_frame`; FSM stays IDLE.
- GRANT: `fmt_grant`=1 for exactly one cycle, then WAIT_START. Space for `fmt_length` words is reserved at grant; the reservation is subtracted from `free_words` until written.
- WAIT_START:
  - `fmt_start`=1 writes beat 1 of the packet (`out_last` = 1 if length==1). Next state is RECV, or IDLE if length==1.
  - `fmt_end` must equal 1 exactly on a length-1 packet; any mismatch sets `err_frame`.
  - If START_TIMEOUT cycles elapse without `fmt_start`: set `err_timeout`, release the reservation, return to IDLE.
- RECV:
  - Every cycle writes one beat; the formatter sends contiguously.
  - The beat counter increments; the beat with count==length is tagged last and returns the FSM to IDLE.
  - `fmt_start`=1 in RECV sets `err_frame`.
  - `fmt_end` not coincident with the counted last beat sets `err_frame`.
  - The beat count always governs; `fmt_end` never truncates or extends a packet.
- Back-to-back packets: a new grant is evaluated the cycle after returning to IDLE. Minimum gap is 1 cycle between a last beat and the next grant.
- FIFO is first-word fall-through:
  - `out_*` shows the head entry; pop occurs when `out_valid` && `out_ready`.
  - Write and pop in the same cycle are allowed; `free_words` reflects both.
  - Overflow is impossible by construction because of the reservation. Pop from empty is ignored.
- Data words are 35 bits wide: data[31:0], chid[1:0], last.
- `err_clr` clears both sticky errors. If `err_clr` and a new error event occur in the same cycle, the set wins.
- `free_words` = DEPTH − stored − reserved_outstanding; it is registered and updates on the cycle after the event.

Optional Feature:
- Macro: MCDF_FMT_SINK_STATS_EN.
- With the macro defined, extra outputs `pkt_cnt0`, `pkt_cnt1`, `pkt_cnt2` (16 bits each):
  - Each counts completed packets per chid 0..2, incrementing on the last beat written.
  - Each wraps 0xFFFF->0 and is cleared by `rst` only.
  - chid 3 is not counted.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single packet: `fmt_req`, chid=1, length=8 in IDLE -> `fmt_grant` pulse 2 cycles later. Start beat then 8 contiguous beats 0x100..0x107 -> drain (`out_ready`=1) yields 0x100..0x107, chid 1, `out_last` only on 0x107, no errors.
- Backpressure/space: `out_ready`=0, DEPTH=64, seven length-8 packets stored (`free_words`=8) -> a length-16 request is not granted. Pop 8 words -> grant issued.
- Framing: length=4 packet with `fmt_end` asserted on beat 3 -> `err_frame`=1. 4 words still stored, last on beat 4. `err_clr` -> 0.
- Timeout: grant issued, `fmt_start` withheld 15 cycles -> `err_timeout`=1, FSM IDLE, `free_words` back to pre-grant value.
- Zero length: `fmt_req` with length=0 -> no grant, `err_frame`=1.
- Reset mid-packet: assert `rst` after beat 2 of 8 -> outputs at reset values, `free_words`=DEPTH. A subsequent length-4 packet is received cleanly.
